// File: rtl/core_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package core_fetch_pkg;

   localparam int unsigned IMEM_WORD_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      REQ_LO,
      WAIT_LO,
      REQ_HI,
      WAIT_HI,
      RESP,
      DRAIN
   } fetch_state_e;

endpackage

// File: rtl/core_fetch_aligner.sv
// Fetch aligner: turns halfword-aligned PCs into 16/32-bit instructions from a
// word-wide instruction memory, with a single-word reuse buffer.
module core_fetch_aligner
   import core_fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 'h1000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   input  logic [XLEN-1:0] req_pc_i,
   output logic            req_ready_o,
   input  logic            flush_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [31:0]     rsp_instr_o,
   output logic [XLEN-1:0] rsp_pc_o,
   output logic            rsp_compressed_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i
);

   fetch_state_e    state;
   logic [XLEN-1:0] pc_q;
   logic            buf_vld;
   logic [XLEN-1:0] buf_addr;
   logic [31:0]     buf_data;
   logic [15:0]     half_q;

   logic            accept;
   logic [XLEN-1:0] req_word;
   logic [15:0]     hit_half;
   logic            hit_rvc;
   logic            buf_hit;
   logic [15:0]     lo_half;
   logic            lo_rvc;

   assign req_ready_o = (state == IDLE) && !flush_i;
   assign accept      = req_valid_i && req_ready_o;
   assign req_word    = {req_pc_i[XLEN-1:2], 2'b00};

   // A hit needs the whole instruction in the buffered word: an upper-half
   // start must be compressed, otherwise the second half lives in the next word.
   assign hit_half = req_pc_i[1] ? buf_data[31:16] : buf_data[15:0];
   assign hit_rvc  = hit_half[1:0] != 2'b11;
   assign buf_hit  = buf_vld && (buf_addr == req_word) && (!req_pc_i[1] || hit_rvc);

   assign lo_half  = pc_q[1] ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
   assign lo_rvc   = lo_half[1:0] != 2'b11;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state            <= IDLE;
         pc_q             <= '0;
         buf_vld          <= 1'b0;
         buf_addr         <= '0;
         buf_data         <= '0;
         half_q           <= '0;
         rsp_valid_o      <= 1'b0;
         rsp_instr_o      <= '0;
         rsp_compressed_o <= 1'b0;
         rsp_pc_o         <= RESET_PC;
         imem_req_o       <= 1'b0;
         imem_addr_o      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  pc_q <= req_pc_i;
                  if (buf_hit) begin
                     state            <= RESP;
                     rsp_valid_o      <= 1'b1;
                     rsp_pc_o         <= req_pc_i;
                     rsp_compressed_o <= hit_rvc;
                     rsp_instr_o      <= hit_rvc ? {16'h0, hit_half} : buf_data;
                  end else begin
                     state       <= REQ_LO;
                     imem_req_o  <= 1'b1;
                     imem_addr_o <= req_word;
                  end
               end
            end
            REQ_LO, REQ_HI: begin
               if (flush_i) begin
                  imem_req_o <= 1'b0;
                  state      <= imem_gnt_i ? DRAIN : IDLE;
               end else if (imem_gnt_i) begin
                  imem_req_o <= 1'b0;
                  state      <= (state == REQ_LO) ? WAIT_LO : WAIT_HI;
               end
            end
            WAIT_LO: begin
               if (flush_i) begin
                  state <= imem_rvalid_i ? IDLE : DRAIN;
               end else if (imem_rvalid_i) begin
                  buf_vld  <= 1'b1;
                  buf_addr <= imem_addr_o;
                  buf_data <= imem_rdata_i;
                  if (pc_q[1] && !lo_rvc) begin
                     half_q      <= lo_half;
                     state       <= REQ_HI;
                     imem_req_o  <= 1'b1;
                     imem_addr_o <= imem_addr_o + XLEN'(IMEM_WORD_BYTES);
                  end else begin
                     state            <= RESP;
                     rsp_valid_o      <= 1'b1;
                     rsp_pc_o         <= pc_q;
                     rsp_compressed_o <= lo_rvc;
                     rsp_instr_o      <= lo_rvc ? {16'h0, lo_half} : imem_rdata_i;
                  end
               end
            end
            WAIT_HI: begin
               if (flush_i) begin
                  state <= imem_rvalid_i ? IDLE : DRAIN;
               end else if (imem_rvalid_i) begin
                  buf_vld          <= 1'b1;
                  buf_addr         <= imem_addr_o;
                  buf_data         <= imem_rdata_i;
                  state            <= RESP;
                  rsp_valid_o      <= 1'b1;
                  rsp_pc_o         <= pc_q;
                  rsp_compressed_o <= 1'b0;
                  rsp_instr_o      <= {imem_rdata_i[15:0], half_q};
               end
            end
            RESP: begin
               if (flush_i || rsp_ready_i) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
               end
            end
            DRAIN: begin
               if (imem_rvalid_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
